// File: rtl/fence_flush_seq_if.sv
// Handshake bundle between commit/CSR, the caches/MMU and the fence sequencer.
interface fence_flush_seq_if;
  logic fence_req_i;
  logic fence_i_req_i;
  logic sfence_req_i;
  logic flush_dcache_o;
  logic flush_dcache_ack_i;
  logic flush_icache_o;
  logic flush_tlb_o;
  logic set_pc_commit_o;
  logic halt_o;
  logic busy_o;
  logic timeout_o;

  modport slave (
    input  fence_req_i, fence_i_req_i, sfence_req_i, flush_dcache_ack_i,
    output flush_dcache_o, flush_icache_o, flush_tlb_o, set_pc_commit_o,
           halt_o, busy_o, timeout_o
  );

  modport master (
    output fence_req_i, fence_i_req_i, sfence_req_i, flush_dcache_ack_i,
    input  flush_dcache_o, flush_icache_o, flush_tlb_o, set_pc_commit_o,
           halt_o, busy_o, timeout_o
  );
endinterface

// File: rtl/fence_flush_seq.sv
// Fence / fence.i / sfence.vma sequencer: halts commit, runs DCache flush,
// ICache invalidate and TLB flush in order, then restarts fetch at commit PC.
module fence_flush_seq #(
  parameter bit          WT_DCACHE           = 1'b0,
  parameter int unsigned ICACHE_FLUSH_CYCLES = 1,
  parameter int unsigned DCACHE_TIMEOUT      = 1024,
  parameter int unsigned CNT_W               = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fence_flush_seq_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DCACHE = 3'd1;
  localparam logic [2:0] S_ICACHE = 3'd2;
  localparam logic [2:0] S_TLB    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [2:0]       pend_q, pend_d;   // {F, FI, SF}
  logic [2:0]       act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             flush_dcache_q, flush_icache_q, flush_tlb_q, set_pc_q;
  logic [2:0]       req;

  assign req = {bus.fence_req_i, bus.fence_i_req_i, bus.sfence_req_i};

  // First phase after 'from' that the active set still needs; unneeded phases take zero cycles.
  function automatic logic [2:0] next_phase(input logic [2:0] from, input logic [2:0] set);
    logic need_dc, need_ic, need_tlb;
    need_dc  = (set[2] | set[1]) & ~WT_DCACHE;
    need_ic  = set[1];
    need_tlb = set[0];
    if (from == S_IDLE && need_dc)
      return S_DCACHE;
    if ((from == S_IDLE || from == S_DCACHE) && need_ic)
      return S_ICACHE;
    if (from != S_TLB && need_tlb)
      return S_TLB;
    return S_DONE;
  endfunction

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | req;
    act_d     = act_q;
    cnt_d     = cnt_q + CNT_W'(1);
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if ((pend_q | req) != 3'b000) begin
          act_d   = pend_q | req;
          pend_d  = '0;
          state_d = next_phase(S_IDLE, pend_q | req);
        end
      end
      S_DCACHE: begin
        if (bus.flush_dcache_ack_i) begin
          state_d = next_phase(S_DCACHE, act_q);
        end else if (DCACHE_TIMEOUT != 0 && cnt_q == CNT_W'(DCACHE_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = next_phase(S_DCACHE, act_q);
        end
      end
      S_ICACHE: begin
        if (cnt_q == CNT_W'(ICACHE_FLUSH_CYCLES - 1))
          state_d = next_phase(S_ICACHE, act_q);
      end
      S_TLB:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q)
      cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      pend_q         <= '0;
      act_q          <= '0;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      flush_dcache_q <= 1'b0;
      flush_icache_q <= 1'b0;
      flush_tlb_q    <= 1'b0;
      set_pc_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      act_q          <= act_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
      // Output flops track the state register one-for-one: no input-to-output path.
      flush_dcache_q <= (state_d == S_DCACHE);
      flush_icache_q <= (state_d == S_ICACHE);
      flush_tlb_q    <= (state_d == S_TLB);
      set_pc_q       <= (state_d == S_DONE);
    end
  end

  assign bus.flush_dcache_o  = flush_dcache_q;
  assign bus.flush_icache_o  = flush_icache_q;
  assign bus.flush_tlb_o     = flush_tlb_q;
  assign bus.set_pc_commit_o = set_pc_q;
  assign bus.halt_o          = (state_q != S_IDLE);
  assign bus.busy_o          = (state_q != S_IDLE);
  assign bus.timeout_o       = timeout_q;

endmodule

// File: tb/tb_fence_flush_seq.sv
// Directed cycle-table bench for fence_flush_seq: two configurations, expected
// output vectors per cycle written out by hand.
module tb_fence_flush_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fence_flush_seq_if ifa ();
  fence_flush_seq_if ifb ();

  fence_flush_seq #(
    .WT_DCACHE(1'b0), .ICACHE_FLUSH_CYCLES(2), .DCACHE_TIMEOUT(8), .CNT_W(11)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave)
  );

  fence_flush_seq #(
    .WT_DCACHE(1'b1), .ICACHE_FLUSH_CYCLES(1), .DCACHE_TIMEOUT(8), .CNT_W(11)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // stim bits: {rst_n, fence, fence_i, sfence, ack}
  // expv bits: {busy, halt, flush_dcache, flush_icache, flush_tlb, set_pc, timeout}
  logic [4:0] stim [16];
  logic [6:0] expv [16];

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] obs(input bit sel);
    if (sel)
      return {ifb.busy_o, ifb.halt_o, ifb.flush_dcache_o, ifb.flush_icache_o,
              ifb.flush_tlb_o, ifb.set_pc_commit_o, ifb.timeout_o};
    return {ifa.busy_o, ifa.halt_o, ifa.flush_dcache_o, ifa.flush_icache_o,
            ifa.flush_tlb_o, ifa.set_pc_commit_o, ifa.timeout_o};
  endfunction

  task automatic drive(input bit sel, input logic [3:0] v);
    if (sel) begin
      ifb.fence_req_i = v[3]; ifb.fence_i_req_i = v[2];
      ifb.sfence_req_i = v[1]; ifb.flush_dcache_ack_i = v[0];
    end else begin
      ifa.fence_req_i = v[3]; ifa.fence_i_req_i = v[2];
      ifa.sfence_req_i = v[1]; ifa.flush_dcache_ack_i = v[0];
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 16; i++) begin
      stim[i] = 5'b10000;
      expv[i] = '0;
    end
  endtask

  // Each table row is one clock cycle; inputs go in 1 unit after the edge, outputs sampled 1 unit later.
  task automatic run(input string name, input bit sel, input int n);
    for (int c = 0; c < n; c++) begin
      rst_n = stim[c][4];
      drive(sel, stim[c][3:0]);
      #1;
      check_eq($sformatf("%s_c%0d", name, c), obs(sel), expv[c]);
      @(posedge clk);
      #1;
    end
    drive(sel, 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0000);
    rst_n = 1'b0;
    #2;
    check_eq("reset_a", obs(1'b0), 7'b0000000);
    check_eq("reset_b", obs(1'b1), 7'b0000000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fence.i: DCache c1-c4 (ack c4), ICache c5-c6, restart c7
    clear_tbl();
    stim[0] = 5'b10100;
    stim[4] = 5'b10001;
    for (int c = 1; c <= 4; c++) expv[c] = 7'b1110000;
    expv[5] = 7'b1101000;
    expv[6] = 7'b1101000;
    expv[7] = 7'b1100010;
    run("fencei", 1'b0, 9);

    // sfence.vma: TLB c1, restart c2; a stray ack during TLB is ignored
    clear_tbl();
    stim[0] = 5'b10010;
    stim[1] = 5'b10001;
    expv[1] = 7'b1100100;
    expv[2] = 7'b1100010;
    run("sfence", 1'b0, 5);

    // fence + sfence merged into one sequence
    clear_tbl();
    stim[0] = 5'b11010;
    stim[3] = 5'b10001;
    for (int c = 1; c <= 3; c++) expv[c] = 7'b1110000;
    expv[4] = 7'b1100100;
    expv[5] = 7'b1100010;
    run("merge", 1'b0, 9);

    // write-through DCache: fence skips straight to DONE; sfence during it runs next
    clear_tbl();
    stim[0] = 5'b11000;
    stim[1] = 5'b10010;
    expv[1] = 7'b1100010;
    expv[3] = 7'b1100100;
    expv[4] = 7'b1100010;
    run("wt", 1'b1, 7);

    // no ack: watchdog expires after 8 DCache cycles, timeout is sticky
    clear_tbl();
    stim[0] = 5'b11000;
    for (int c = 1; c <= 8; c++) expv[c] = 7'b1110000;
    expv[9]  = 7'b1100011;
    expv[10] = 7'b0000001;
    expv[11] = 7'b0000001;
    run("tmo", 1'b0, 12);

    // reset mid-DCache with a fence pending: everything drops, nothing replays
    clear_tbl();
    stim[0] = 5'b11000;
    stim[2] = 5'b11000;
    stim[3] = 5'b00000;
    stim[4] = 5'b00000;
    expv[0] = 7'b0000001;
    expv[1] = 7'b1110001;
    expv[2] = 7'b1110001;
    run("rst", 1'b0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fence_flush_seq.md
Name: fence_flush_seq

Overview:
Sequences multi-phase memory fences for the core: fence, fence.i and sfence.vma. On a request it halts commit, then runs the required phases in order: DCache writeback/flush with ack, ICache invalidate, TLB flush. It then restarts fetch from the commit PC. It sits between the commit/CSR stage and the caches/MMU, beside the pipeline flush control, and replaces the single fence-active flag with an explicit, watchdogged sequence.

Parameters:
WT_DCACHE, 0, 1 = write-through DCache; skip the DCache phase entirely.
ICACHE_FLUSH_CYCLES, 1, cycles flush_icache_o stays high (>=1).
DCACHE_TIMEOUT, 1024, max cycles waiting for the DCache ack; 0 disables the watchdog.
CNT_W, 11, counter width; must hold max(DCACHE_TIMEOUT, ICACHE_FLUSH_CYCLES).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fence_req_i  in  1  fence committed (single-cycle pulse)
fence_i_req_i  in  1  fence.i committed (pulse)
sfence_req_i  in  1  sfence.vma committed (pulse)
flush_dcache_o  out  1  DCache flush request, level, registered
flush_dcache_ack_i  in  1  DCache flush complete (pulse)
flush_icache_o  out  1  ICache invalidate, registered
flush_tlb_o  out  1  TLB flush, one-cycle pulse, registered
set_pc_commit_o  out  1  one-cycle pulse: restart fetch at commit PC
halt_o  out  1  halt commit stage
busy_o  out  1  sequence in progress
timeout_o  out  1  sticky: DCache ack watchdog expired

Behaviour:
- Reset (async, rst_ni low): state IDLE, pending mask 0, counter 0. All outputs 0. Reset mid-sequence aborts immediately and drops all outputs; there is no pending replay.
- Pending mask {F, FI, SF}: each request pulse sets its bit in any state. A bit clears when a sequence that includes it starts, i.e. on leaving IDLE.
- States: IDLE, DCACHE, ICACHE, TLB, DONE.
- IDLE: if mask != 0 (or a request arrives this cycle, both counted), snapshot mask into the active set, clear the pending bits, and go to the first needed phase next cycle.
- Phase order and need:
  - DCACHE if (F|FI) && !WT_DCACHE.
  - ICACHE if FI.
  - TLB if SF.
  - DONE always.
  - Phases not needed are skipped with zero cycles.
- DCACHE:
  - flush_dcache_o = 1 in every cycle spent in DCACHE.
  - Counter increments each cycle.
  - ack sampled high -> next phase; flush_dcache_o is 0 in that next cycle.
  - If DCACHE_TIMEOUT != 0 and the counter reaches DCACHE_TIMEOUT-1 without ack: set timeout_o and proceed as if acked.
  - An ack outside DCACHE is ignored.
- ICACHE: flush_icache_o = 1 for exactly ICACHE_FLUSH_CYCLES cycles (counter), then next phase.
- TLB: flush_tlb_o = 1 for exactly one cycle, then DONE.
- DONE: set_pc_commit_o = 1 for one cycle. Next state is IDLE; if pending != 0, the next sequence starts on the following IDLE cycle.
- Outputs:
  - halt_o = busy_o = (state != IDLE), decoded from the state register.
  - flush_* outputs and set_pc_commit_o are state-decoded flops, so they have no combinational path from inputs.
  - Latency from request to first phase output: 1 cycle.
- Counter resets to 0 on every phase entry.
- timeout_o clears only on reset.
- Simultaneous requests in the same cycle merge into one sequence, and each phase runs at most once.
- A request during an active sequence is never lost and runs in the following sequence. It is not merged into the current one, because the caches may already be past that phase.

Test Plan:
- fence_i_req_i pulse at c0, WT_DCACHE=0, ICACHE_FLUSH_CYCLES=2, ack at c4 -> flush_dcache_o high c1–c4; flush_icache_o high c5–c6; set_pc_commit_o at c7; halt_o high c1–c7, low c8; flush_tlb_o never high.
- sfence_req_i at c0 -> flush_tlb_o at c1 only; set_pc_commit_o at c2; no DCache/ICache activity; halt_o high c1–c2.
- fence_req_i + sfence_req_i both at c0, ack at c3 -> flush_dcache_o c1–c3; flush_tlb_o c4; set_pc_commit_o c5; exactly one sequence.
- fence_req_i at c0, no ack, DCACHE_TIMEOUT=8 -> flush_dcache_o c1–c8; timeout_o rises at c9 and stays; set_pc_commit_o c9; IDLE c10.
- WT_DCACHE=1, fence_req_i at c0 -> set_pc_commit_o c1, idle c2. Then sfence_req_i at c1 -> second sequence with flush_tlb_o at c3 and set_pc_commit_o at c4.
- rst_ni low at c3 during DCACHE, with a fence request pending -> all outputs 0 immediately; after release the block stays IDLE with no request replayed.
